// File: rtl/cache_pkg.sv
// Shared cache/memory package: line and beat geometry
// plus the burst adapter state encoding.
package cache_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int BEATS    = LINE_W / BEAT_W;
  localparam int BEAT_CW  = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } burst_state_t;

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-line request port and memory burst port of the
// line burst adapter; slave is the adapter side.
interface line_burst_adapter_if;
  import cache_pkg::*;

  logic [ADDR_W-1:0] line_addr_i;
  logic              line_read_i;
  logic              line_write_i;
  logic [LINE_W-1:0] line_wdata_i;
  logic [LINE_W-1:0] line_rdata_o;
  logic              line_resp_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [BEAT_W-1:0] mem_wdata_o;
  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_resp_i;

  modport slave (
    input  line_addr_i, line_read_i, line_write_i,
    input  line_wdata_i, mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o, mem_addr_o,
    output mem_read_o, mem_write_o, mem_wdata_o
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i,
    output line_wdata_i, mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o, mem_addr_o,
    input  mem_read_o, mem_write_o, mem_wdata_o
  );

endinterface

// File: rtl/line_burst_adapter.sv
// Turns one cache-line read/write into a 4-beat memory
// burst through a local line buffer.
module line_burst_adapter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  line_burst_adapter_if.slave  bus
);

  localparam logic [BEAT_CW-1:0] LAST = BEAT_CW'(BEATS-1);

  burst_state_t        state_q, state_d;
  logic [BEAT_CW-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_aligned;

  assign addr_aligned = {bus.line_addr_i[ADDR_W-1:OFFSET_W],
                         OFFSET_W'(0)};

  // Next-state: accept in IDLE, step beats on mem_resp_i
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.line_read_i) begin
          addr_d  = addr_aligned;
          beat_d  = '0;
          state_d = ST_READ;
        end else if (bus.line_write_i) begin
          addr_d  = addr_aligned;
          beat_d  = '0;
          buf_d   = bus.line_wdata_i;
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (bus.mem_resp_i) begin
          buf_d[BEAT_W*beat_q +: BEAT_W] = bus.mem_rdata_i;
          beat_d = beat_q + BEAT_CW'(1);
          if (beat_q == LAST) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (bus.mem_resp_i) begin
          beat_d = beat_q + BEAT_CW'(1);
          if (beat_q == LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset also discards any partial line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_read_o   = (state_q == ST_READ);
  assign bus.mem_write_o  = (state_q == ST_WRITE);
  assign bus.line_resp_o  = (state_q == ST_DONE);
  assign bus.line_rdata_o = buf_q;
  assign bus.mem_wdata_o  = (state_q == ST_WRITE)
                          ? buf_q[BEAT_W*beat_q +: BEAT_W]
                          : '0;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: vector table
// plus hand sequences for dual request, reset, back-to-back.
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_burst_adapter_if bus();

  line_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [63:0] R0 = 64'hDEAD_BEEF_CAFE_0000;
  localparam logic [63:0] R1 = 64'hDEAD_BEEF_CAFE_0001;
  localparam logic [63:0] R2 = 64'hDEAD_BEEF_CAFE_0002;
  localparam logic [63:0] R3 = 64'hDEAD_BEEF_CAFE_0003;
  localparam logic [255:0] RL = {R3, R2, R1, R0};
  localparam logic [63:0] W0 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] W1 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h1111_1111_1111_1111;
  localparam logic [255:0] WL = {W3, W2, W1, W0};

  typedef struct {
    logic        r;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic        rs;
    logic [63:0] d;
    logic        e_rd;
    logic        e_wr;
    logic        e_resp;
    logic [31:0] e_a;
    logic [63:0] e_wd;
    logic        cl;
    logic [255:0] e_l;
  } vec_t;

  vec_t tv[18];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    logic r, logic rd, logic wr, logic [31:0] a,
    logic rs, logic [63:0] d,
    logic e_rd, logic e_wr, logic e_resp,
    logic [31:0] e_a, logic [63:0] e_wd,
    logic cl, logic [255:0] e_l);
    vec_t v;
    v.r = r; v.rd = rd; v.wr = wr; v.a = a;
    v.rs = rs; v.d = d;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
    v.e_a = e_a; v.e_wd = e_wd;
    v.cl = cl; v.e_l = e_l;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] got,
                     logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_out(string tag, logic e_rd,
                         logic e_wr, logic e_resp,
                         logic [31:0] e_a,
                         logic [63:0] e_wd);
    chk({tag, ".mem_read"}, 256'(bus.mem_read_o), 256'(e_rd));
    chk({tag, ".mem_write"}, 256'(bus.mem_write_o), 256'(e_wr));
    chk({tag, ".line_resp"}, 256'(bus.line_resp_o),
        256'(e_resp));
    chk({tag, ".mem_addr"}, 256'(bus.mem_addr_o), 256'(e_a));
    chk({tag, ".mem_wdata"}, 256'(bus.mem_wdata_o),
        256'(e_wd));
  endtask

  task automatic drive(logic r, logic rd, logic wr,
                       logic [31:0] a, logic rs,
                       logic [63:0] d);
    rst              = r;
    bus.line_read_i  = rd;
    bus.line_write_i = wr;
    bus.line_addr_i  = a;
    bus.mem_resp_i   = rs;
    bus.mem_rdata_i  = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] exp_l;
    logic [63:0]  bd;

    bus.line_wdata_i = WL;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0);

    tv[0]  = mk(1, 0, 0, 32'h0,    0, 64'h0,
                0, 0, 0, 32'h0,    64'h0, 1, 256'h0);
    tv[1]  = mk(0, 1, 0, 32'h1234, 0, 64'h0,
                1, 0, 0, 32'h1220, 64'h0, 0, 256'h0);
    tv[2]  = mk(0, 0, 0, 32'h0,    1, R0,
                1, 0, 0, 32'h1220, 64'h0, 0, 256'h0);
    tv[3]  = mk(0, 0, 0, 32'h0,    1, R1,
                1, 0, 0, 32'h1220, 64'h0, 0, 256'h0);
    tv[4]  = mk(0, 0, 0, 32'h0,    1, R2,
                1, 0, 0, 32'h1220, 64'h0, 0, 256'h0);
    tv[5]  = mk(0, 0, 0, 32'h0,    1, R3,
                0, 0, 1, 32'h1220, 64'h0, 1, RL);
    tv[6]  = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 0, 0, 32'h1220, 64'h0, 1, RL);
    tv[7]  = mk(0, 0, 1, 32'h40,   0, 64'h0,
                0, 1, 0, 32'h40,   W0, 0, 256'h0);
    tv[8]  = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 1, 0, 32'h40,   W0, 0, 256'h0);
    tv[9]  = mk(0, 0, 0, 32'h0,    1, 64'h0,
                0, 1, 0, 32'h40,   W1, 0, 256'h0);
    tv[10] = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 1, 0, 32'h40,   W1, 0, 256'h0);
    tv[11] = mk(0, 0, 0, 32'h0,    1, 64'h0,
                0, 1, 0, 32'h40,   W2, 0, 256'h0);
    tv[12] = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 1, 0, 32'h40,   W2, 0, 256'h0);
    tv[13] = mk(0, 0, 0, 32'h0,    1, 64'h0,
                0, 1, 0, 32'h40,   W3, 0, 256'h0);
    tv[14] = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 1, 0, 32'h40,   W3, 0, 256'h0);
    tv[15] = mk(0, 0, 0, 32'h0,    1, 64'h0,
                0, 0, 1, 32'h40,   64'h0, 1, WL);
    tv[16] = mk(0, 0, 0, 32'h0,    0, 64'h0,
                0, 0, 0, 32'h40,   64'h0, 1, WL);
    tv[17] = mk(0, 0, 0, 32'h0,    1, 64'hBAD0,
                0, 0, 0, 32'h40,   64'h0, 1, WL);

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].r, tv[i].rd, tv[i].wr, tv[i].a,
            tv[i].rs, tv[i].d);
      tick();
      chk_out($sformatf("vec%0d", i), tv[i].e_rd,
              tv[i].e_wr, tv[i].e_resp, tv[i].e_a,
              tv[i].e_wd);
      if (tv[i].cl)
        chk($sformatf("vec%0d.line_rdata", i),
            bus.line_rdata_o, tv[i].e_l);
    end

    // read and write together: read wins
    bus.line_wdata_i = ~WL;
    drive(0, 1, 1, 32'h9C, 0, 64'h0);
    tick();
    chk_out("both.acc", 1, 0, 0, 32'h80, 64'h0);
    exp_l = '0;
    for (int k = 0; k < 4; k++) begin
      bd = 64'h5500 + 64'(k);
      exp_l[64*k +: 64] = bd;
      drive(0, 0, 0, 32'h0, 1, bd);
      tick();
      if (k < 3)
        chk_out($sformatf("both.b%0d", k), 1, 0, 0,
                32'h80, 64'h0);
      else
        chk_out("both.done", 0, 0, 1, 32'h80, 64'h0);
    end
    chk("both.line_rdata", bus.line_rdata_o, exp_l);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    tick();
    chk_out("both.idle", 0, 0, 0, 32'h80, 64'h0);

    // reset after beat 2 of a read
    drive(0, 1, 0, 32'h300, 0, 64'h0);
    tick();
    chk_out("rst.acc", 1, 0, 0, 32'h300, 64'h0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 32'h0, 1, 64'h7700 + 64'(k));
      tick();
      chk_out($sformatf("rst.b%0d", k), 1, 0, 0,
              32'h300, 64'h0);
    end
    drive(1, 0, 0, 32'h0, 1, 64'h7703);
    tick();
    chk_out("rst.abort", 0, 0, 0, 32'h0, 64'h0);
    chk("rst.line_rdata", bus.line_rdata_o, 256'h0);
    drive(0, 0, 0, 32'h0, 0, 64'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("rst.quiet%0d", k), 0, 0, 0,
              32'h0, 64'h0);
    end

    // back-to-back: read, then write right after DONE
    bus.line_wdata_i = WL;
    drive(0, 1, 0, 32'h41F, 0, 64'h0);
    tick();
    chk_out("b2b.acc", 1, 0, 0, 32'h400, 64'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 32'h0, 1, 64'h9900 + 64'(k));
      tick();
    end
    chk_out("b2b.rdone", 0, 0, 1, 32'h400, 64'h0);
    drive(0, 0, 1, 32'h5A0, 1, 64'h0);
    tick();
    chk_out("b2b.ignored", 0, 0, 0, 32'h400, 64'h0);
    tick();
    chk_out("b2b.wacc", 0, 1, 0, 32'h5A0, W0);
    drive(0, 0, 0, 32'h0, 1, 64'h0);
    tick();
    chk_out("b2b.w1", 0, 1, 0, 32'h5A0, W1);
    tick();
    chk_out("b2b.w2", 0, 1, 0, 32'h5A0, W2);
    tick();
    chk_out("b2b.w3", 0, 1, 0, 32'h5A0, W3);
    tick();
    chk_out("b2b.wdone", 0, 0, 1, 32'h5A0, 64'h0);
    drive(0, 0, 0, 32'h0, 1, 64'h0);
    tick();
    chk_out("b2b.idle", 0, 0, 0, 32'h5A0, 64'h0);
    chk("b2b.line_rdata", bus.line_rdata_o, WL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
